// File: rtl/pc_npc.sv
// Program counter and next-PC selection for the single-cycle MIPS datapath.
// PC is a register updated only on the clock edge. NPC, PCPlus4 and Taken are
// combinational. An illegal next PC (misaligned or outside instruction memory)
// sends the block into a sticky HALT state that only reset clears. The
// retired-instruction counter saturates instead of wrapping.
module pc_npc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  NPCOp,
  input  logic        CMPOut,
  input  logic [15:0] Imm16,
  input  logic [25:0] Imm26,
  input  logic [31:0] RegData,
  input  logic        Stall,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] NPC,
  output logic        Taken,
  output logic        Halt,
  output logic [31:0] InstrCount
);

  // Next-PC select encodings.
  localparam logic [7:0] OP_PC4 = 8'd0;
  localparam logic [7:0] OP_BR  = 8'd1;
  localparam logic [7:0] OP_J   = 8'd2;
  localparam logic [7:0] OP_JR  = 8'd3;

  // Legal fetch window, held in 33 bits so the upper bound cannot overflow
  // even when the window ends exactly at 2^32.
  localparam logic [32:0] PC_LO = {1'b0, RESET_PC};
  localparam logic [32:0] PC_HI = {1'b0, RESET_PC} + ({1'b0, 32'(IM_WORDS)} << 2);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr_count;
  logic        r_halt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_offset;
  logic [31:0] w_br_target;
  logic [31:0] w_jump_target;
  logic [31:0] w_npc;
  logic [32:0] w_npc_ext;
  logic        w_npc_aligned;
  logic        w_npc_in_range;
  logic        w_npc_legal;
  logic        w_taken;

  // Candidate targets. Jump targets take their upper nibble from PC itself,
  // not from PC+4; there is no delay slot.
  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_br_offset   = {{14{Imm16[15]}}, Imm16, 2'b00};
  assign w_br_target   = w_pc_plus4 + w_br_offset;
  assign w_jump_target = {r_pc[31:28], Imm26, 2'b00};
  assign w_taken       = (NPCOp == OP_BR) & CMPOut;

  // Next-PC mux; unknown op codes fall through to sequential fetch.
  always_comb begin
    w_npc = w_pc_plus4;
    case (NPCOp)
      OP_PC4:  w_npc = w_pc_plus4;
      OP_BR:   w_npc = CMPOut ? w_br_target : w_pc_plus4;
      OP_J:    w_npc = w_jump_target;
      OP_JR:   w_npc = RegData;
      default: w_npc = w_pc_plus4;
    endcase
  end

  // Legality: word aligned and inside [RESET_PC, RESET_PC + 4*IM_WORDS).
  assign w_npc_ext      = {1'b0, w_npc};
  assign w_npc_aligned  = (w_npc[1:0] == 2'b00);
  assign w_npc_in_range = (w_npc_ext >= PC_LO) && (w_npc_ext < PC_HI);
  assign w_npc_legal    = w_npc_aligned && w_npc_in_range;

  // RUN/HALT state machine owning PC, the retire counter and the halt flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_instr_count <= 32'd0;
      r_halt        <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!Stall) begin
            // The instruction retires whether or not its successor is legal.
            if (r_instr_count != CNT_MAX) begin
              r_instr_count <= r_instr_count + 32'd1;
            end
            if (w_npc_legal) begin
              r_pc <= w_npc;
            end else begin
              r_state <= ST_HALT;
              r_halt  <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          // Frozen until reset.
          r_halt <= 1'b1;
        end
        default: begin
          r_state <= ST_HALT;
          r_halt  <= 1'b1;
        end
      endcase
    end
  end

  assign PC         = r_pc;
  assign PCPlus4    = w_pc_plus4;
  assign NPC        = w_npc;
  assign Taken      = w_taken;
  assign Halt       = r_halt;
  assign InstrCount = r_instr_count;

endmodule
